// File: rtl/bbg_pkg.sv
// Shared constants and state encoding for the bit-block generator.
package bbg_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned MAX_BLOCKS = 16;
  localparam int unsigned FEAS_W     = 12;
  localparam int unsigned POS_W      = $clog2(DATA_W);

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t BUILD = 2'd1;
  localparam state_t OUT   = 2'd2;

endpackage

// File: rtl/bbg_req_check.sv
// Combinational feasibility check: does req_cnt blocks of req_len ones plus separators fit a word?
module bbg_req_check
  import bbg_pkg::*;
(
  input  logic [CNT_W-1:0] req_cnt,
  input  logic [CNT_W-1:0] req_len,
  output logic             feasible
);

  logic [FEAS_W-1:0] cnt_w;
  logic [FEAS_W-1:0] len_w;
  logic [FEAS_W-1:0] span;

  always_comb begin
    cnt_w = FEAS_W'(req_cnt);
    len_w = FEAS_W'(req_len);
    // Widened so cnt*len + separators cannot wrap for any 6-bit inputs
    span  = (cnt_w * len_w) + cnt_w - FEAS_W'(1);
    if (req_cnt == '0) begin
      feasible = 1'b1;
    end else begin
      feasible = (req_len != '0) && (req_cnt <= CNT_W'(MAX_BLOCKS)) &&
                 (span <= FEAS_W'(DATA_W));
    end
  end

endmodule

// File: rtl/bit_block_generator.sv
// Serially builds a 32-bit word (MSB first) holding req_cnt runs of req_len ones,
// separated by single zeros, and presents it with a one-cycle data_enb strobe.
module bit_block_generator
  import bbg_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  req_cnt,
  input  logic [CNT_W-1:0]  req_len,
  output logic [DATA_W-1:0] data,
  output logic              data_enb,
  output logic              busy,
  output logic              err
);

  state_t              state_q, state_d;
  logic [POS_W-1:0]    pos_q, pos_d;
  logic [CNT_W-1:0]    run_q, run_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic                sep_q, sep_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                data_enb_q, data_enb_d;
  logic                err_q, err_d;
  logic                feasible;
  logic                bit_val;

  bbg_req_check u_req_check (
    .req_cnt  (req_cnt),
    .req_len  (req_len),
    .feasible (feasible)
  );

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    run_d      = run_q;
    rem_d      = rem_q;
    len_d      = len_q;
    sep_d      = sep_q;
    sr_d       = sr_q;
    data_d     = data_q;
    data_enb_d = 1'b0;
    err_d      = 1'b0;
    bit_val    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (feasible) begin
            rem_d   = req_cnt;
            len_d   = req_len;
            run_d   = '0;
            sep_d   = 1'b0;
            pos_d   = POS_W'(DATA_W - 1);
            sr_d    = '0;
            state_d = BUILD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      BUILD: begin
        // Once all blocks are placed the remaining bits are zero fill
        bit_val      = (rem_q != '0) && !sep_q;
        sr_d[pos_q]  = bit_val;
        if (bit_val) begin
          if (run_q == len_q - CNT_W'(1)) begin
            run_d = '0;
            rem_d = rem_q - CNT_W'(1);
            sep_d = 1'b1;
          end else begin
            run_d = run_q + CNT_W'(1);
          end
        end else if (sep_q) begin
          sep_d = 1'b0;
        end
        if (pos_q == '0) begin
          state_d = OUT;
        end else begin
          pos_d = pos_q - POS_W'(1);
        end
      end

      OUT: begin
        data_d     = sr_q;
        data_enb_d = 1'b1;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      run_q      <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      sep_q      <= 1'b0;
      sr_q       <= '0;
      data_q     <= '0;
      data_enb_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      run_q      <= run_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      sep_q      <= sep_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      data_enb_q <= data_enb_d;
      err_q      <= err_d;
    end
  end

  assign data     = data_q;
  assign data_enb = data_enb_q;
  assign busy     = (state_q != IDLE);
  assign err      = err_q;

endmodule
